// File: rtl/vga_pkg.sv
// Shared VGA definitions: frame size, colour type and the pixel FIFO entry layout.
package vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef logic [2:0] colour_t;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      colour_t    colour;
      logic       vis;
      logic       last;
   } pix_entry_t;

   // Signed clip test; widening to int keeps negative coordinates negative.
   function automatic logic isVisible(input logic signed [9:0] x,
                                      input logic signed [9:0] y,
                                      input int w,
                                      input int h);
      return (int'(x) >= 0) && (int'(x) < w) && (int'(y) >= 0) && (int'(y) < h);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array synchronous FIFO; a separate occupancy count tells full from empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [PW:0]      count_q, count_d;
   logic             doPush, doPop;

   assign full_o  = (count_q == FULL_COUNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rdPtr_q];
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      if (doPush && !doPop)      count_d = count_q + 1'b1;
      else if (!doPush && doPop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/pixel_clip_buffer.sv
// Clips circle-engine pixels against the frame, queues them and issues them to the
// VGA adapter under the arbiter grant, with shape-done pulse and clipped-pixel count.
module pixel_clip_buffer #(
   parameter int DEPTH    = 8,
   parameter int SCREEN_W = vga_pkg::SCREEN_W,
   parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [9:0]  in_x,
   input  logic signed [9:0]  in_y,
   input  logic [2:0]         in_colour,
   input  logic               in_last,
   input  logic               out_ready,
   output logic [7:0]         vga_x,
   output logic [6:0]         vga_y,
   output logic [2:0]         vga_colour,
   output logic               vga_plot,
   output logic               done,
   output logic [15:0]        drop_count,
   input  logic               clr_stats
);

   import vga_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   pix_entry_t    pushEntry, popEntry;
   logic          fifoFull, fifoEmpty;
   logic [CW-1:0] occupancy;
   logic          accept, pop, pixVis;

   logic [7:0]    vgaX_q, vgaX_d;
   logic [6:0]    vgaY_q, vgaY_d;
   colour_t       vgaColour_q, vgaColour_d;
   logic          vgaPlot_q, vgaPlot_d;
   logic          done_q, done_d;
   logic [15:0]   dropCount_q, dropCount_d;

   // Readiness comes only from registered occupancy, never from out_ready.
   assign in_ready = !fifoFull;
   assign accept   = in_valid && in_ready;
   assign pop      = !fifoEmpty && out_ready;
   assign pixVis   = isVisible(in_x, in_y, SCREEN_W, SCREEN_H);

   always_comb begin
      pushEntry.x      = in_x[7:0];
      pushEntry.y      = in_y[6:0];
      pushEntry.colour = in_colour;
      pushEntry.vis    = pixVis;
      pushEntry.last   = in_last;
   end

   sync_fifo #(
      .WIDTH ($bits(pix_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept),
      .pop_i   (pop),
      .wdata_i (pushEntry),
      .rdata_o (popEntry),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (occupancy)
   );

   // Clipped entries still pop so that a clipped last pixel can raise done.
   always_comb begin
      vgaX_d      = vgaX_q;
      vgaY_d      = vgaY_q;
      vgaColour_d = vgaColour_q;
      vgaPlot_d   = 1'b0;
      done_d      = 1'b0;
      if (pop) begin
         vgaX_d      = popEntry.x;
         vgaY_d      = popEntry.y;
         vgaColour_d = popEntry.colour;
         vgaPlot_d   = popEntry.vis;
         done_d      = popEntry.last;
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      dropCount_d = dropCount_q;
      if (clr_stats)
         dropCount_d = '0;
      else if (accept && !pixVis && (dropCount_q != 16'hFFFF))
         dropCount_d = dropCount_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vgaX_q      <= '0;
         vgaY_q      <= '0;
         vgaColour_q <= '0;
         vgaPlot_q   <= 1'b0;
         done_q      <= 1'b0;
         dropCount_q <= '0;
      end else begin
         vgaX_q      <= vgaX_d;
         vgaY_q      <= vgaY_d;
         vgaColour_q <= vgaColour_d;
         vgaPlot_q   <= vgaPlot_d;
         done_q      <= done_d;
         dropCount_q <= dropCount_d;
      end
   end

   // Sanity check that the FIFO's full flag agrees with its own occupancy.
   always @(posedge clk) begin
      if (rst_n) assert (fifoFull == (occupancy == CW'(DEPTH)));
   end

   assign vga_x      = vgaX_q;
   assign vga_y      = vgaY_q;
   assign vga_colour = vgaColour_q;
   assign vga_plot   = vgaPlot_q;
   assign done       = done_q;
   assign drop_count = dropCount_q;

endmodule

// File: tb/tb_pixel_clip_buffer.sv
// Directed self-checking bench for pixel_clip_buffer: latency, clipping, backpressure,
// shape completion, asynchronous reset flush and drop-count saturation/clear.
module tb_pixel_clip_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [9:0]  inX;
   logic [9:0]  inY;
   logic [2:0]  inColour;
   logic        inLast;
   logic        outReady;
   logic [7:0]  vgaX;
   logic [6:0]  vgaY;
   logic [2:0]  vgaColour;
   logic        vgaPlot;
   logic        done;
   logic [15:0] dropCount;
   logic        clrStats;

   int checkCount = 0;
   int passCount  = 0;
   int cycleCount = 0;

   typedef struct {
      int x;
      int y;
      int c;
      int cyc;
   } plotRec_t;

   plotRec_t plotLog[$];
   int       doneCount = 0;
   int       doneCycle = 0;
   logic     doneWithPlot = 1'b0;

   always #5 clk = ~clk;

   pixel_clip_buffer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_x       (inX),
      .in_y       (inY),
      .in_colour  (inColour),
      .in_last    (inLast),
      .out_ready  (outReady),
      .vga_x      (vgaX),
      .vga_y      (vgaY),
      .vga_colour (vgaColour),
      .vga_plot   (vgaPlot),
      .done       (done),
      .drop_count (dropCount),
      .clr_stats  (clrStats)
   );

   // Cycle numbering advances on each rising edge.
   always @(posedge clk) cycleCount++;

   // Record every plot and done pulse half a cycle after the edge that produced it.
   always @(negedge clk) begin
      if (vgaPlot === 1'b1)
         plotLog.push_back('{int'(vgaX), int'(vgaY), int'(vgaColour), cycleCount});
      if (done === 1'b1) begin
         doneCount++;
         doneCycle    = cycleCount;
         doneWithPlot = vgaPlot;
      end
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checkCount++;
      if (observed == expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic valid, input int x, input int y,
                                input int c, input logic last);
      inValid  = valid;
      inX      = 10'(x);
      inY      = 10'(y);
      inColour = 3'(c);
      inLast   = last;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pixKey(input int x, input int y, input int c);
      return x * 10000 + y * 10 + c;
   endfunction

   initial begin
      int baseCycle;

      rst_n    = 1'b0;
      outReady = 1'b0;
      clrStats = 1'b0;
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      repeat (2) tick();

      checkOutput("rst_in_ready", inReady, 1);
      checkOutput("rst_plot", vgaPlot, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_x", vgaX, 0);
      checkOutput("rst_y", vgaY, 0);
      checkOutput("rst_colour", vgaColour, 0);
      checkOutput("rst_drop", dropCount, 0);
      rst_n = 1'b1;
      tick();

      // Single visible pixel: accepted in N, plotted in N+2 only.
      outReady = 1'b1;
      applyStimulus(1'b1, 10, 20, 3, 1'b0);
      checkOutput("lat_ready", inReady, 1);
      tick();
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      checkOutput("lat_plot_n1", vgaPlot, 0);
      tick();
      checkOutput("lat_plot_n2", vgaPlot, 1);
      checkOutput("lat_x", vgaX, 10);
      checkOutput("lat_y", vgaY, 20);
      checkOutput("lat_colour", vgaColour, 3);
      tick();
      checkOutput("lat_plot_n3", vgaPlot, 0);

      // Four clipped pixels: they pop but never plot.
      plotLog.delete();
      applyStimulus(1'b1, -1, 0, 1, 1'b0);   tick();
      applyStimulus(1'b1, 160, 0, 2, 1'b0);  tick();
      applyStimulus(1'b1, 0, 120, 4, 1'b0);  tick();
      applyStimulus(1'b1, 5, -5, 6, 1'b0);   tick();
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      repeat (4) tick();
      checkOutput("clip_plots", plotLog.size(), 0);
      checkOutput("clip_last_x", vgaX, 5);
      checkOutput("clip_last_y", vgaY, 123);
      checkOutput("clip_last_colour", vgaColour, 6);
      checkOutput("clip_drop", dropCount, 4);

      // Bottom-right corner is inside the frame.
      applyStimulus(1'b1, 159, 119, 7, 1'b0);
      tick();
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      tick();
      checkOutput("corner_plot", vgaPlot, 1);
      checkOutput("corner_x", vgaX, 159);
      checkOutput("corner_y", vgaY, 119);
      checkOutput("corner_colour", vgaColour, 7);
      tick();
      checkOutput("corner_drop", dropCount, 4);

      // Backpressure: fill all eight slots with out_ready low.
      outReady = 1'b0;
      plotLog.delete();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 20 + i * 10, 30 + i, i, 1'b0);
         checkOutput($sformatf("bp_ready_%0d", i), inReady, 1);
         tick();
      end
      checkOutput("bp_full_ready", inReady, 0);
      applyStimulus(1'b1, 110, 60, 5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("bp_hold_%0d", i), inReady, 0);
         tick();
      end
      checkOutput("bp_no_plot_while_blocked", plotLog.size(), 0);

      // Grant arrives with the 9th still offered: no same-cycle refill.
      outReady = 1'b1;
      checkOutput("full_pop_ready", inReady, 0);
      tick();
      checkOutput("full_after_pop_ready", inReady, 1);
      tick();
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      repeat (12) tick();
      checkOutput("bp_plot_count", plotLog.size(), 9);
      if (plotLog.size() == 9) begin
         baseCycle = plotLog[0].cyc;
         for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("bp_order_%0d", i),
                        pixKey(plotLog[i].x, plotLog[i].y, plotLog[i].c),
                        pixKey(20 + i * 10, 30 + i, i));
            checkOutput($sformatf("bp_cycle_%0d", i), plotLog[i].cyc, baseCycle + i);
         end
         checkOutput("bp_ninth", pixKey(plotLog[8].x, plotLog[8].y, plotLog[8].c),
                     pixKey(110, 60, 5));
         checkOutput("bp_ninth_cycle", plotLog[8].cyc, baseCycle + 8);
      end
      checkOutput("bp_drop", dropCount, 4);

      // Shape end on a clipped last pixel.
      plotLog.delete();
      doneCount = 0;
      applyStimulus(1'b1, 1, 1, 1, 1'b0);    tick();
      applyStimulus(1'b1, 2, 2, 2, 1'b0);    tick();
      applyStimulus(1'b1, 200, 3, 4, 1'b1);  tick();
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      repeat (6) tick();
      checkOutput("shape_plots", plotLog.size(), 2);
      checkOutput("shape_done_count", doneCount, 1);
      checkOutput("shape_done_plot", doneWithPlot, 0);
      if (plotLog.size() == 2) begin
         checkOutput("shape_p0", pixKey(plotLog[0].x, plotLog[0].y, plotLog[0].c), pixKey(1, 1, 1));
         checkOutput("shape_p1", pixKey(plotLog[1].x, plotLog[1].y, plotLog[1].c), pixKey(2, 2, 2));
         checkOutput("shape_done_cycle", doneCycle, plotLog[1].cyc + 1);
      end
      checkOutput("shape_x_held", vgaX, 200);
      checkOutput("shape_drop", dropCount, 5);

      // Asynchronous reset with five entries queued.
      outReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 10 + i, 10 + i, 1, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_plot", vgaPlot, 0);
      checkOutput("arst_done", done, 0);
      checkOutput("arst_x", vgaX, 0);
      checkOutput("arst_y", vgaY, 0);
      checkOutput("arst_colour", vgaColour, 0);
      checkOutput("arst_drop", dropCount, 0);
      checkOutput("arst_ready", inReady, 1);
      tick();
      rst_n     = 1'b1;
      outReady  = 1'b1;
      plotLog.delete();
      doneCount = 0;
      repeat (10) tick();
      checkOutput("arst_no_plots", plotLog.size(), 0);
      checkOutput("arst_no_done", doneCount, 0);

      applyStimulus(1'b1, 7, 8, 2, 1'b0);
      tick();
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      repeat (4) tick();
      checkOutput("arst_fresh_count", plotLog.size(), 1);
      if (plotLog.size() == 1)
         checkOutput("arst_fresh_pix", pixKey(plotLog[0].x, plotLog[0].y, plotLog[0].c),
                     pixKey(7, 8, 2));

      // Saturate the drop counter with a long clipped stream, then clear mid-stream.
      plotLog.delete();
      applyStimulus(1'b1, -1, 0, 0, 1'b0);
      repeat (65540) @(posedge clk);
      #1;
      checkOutput("sat_drop", dropCount, 16'hFFFF);
      checkOutput("sat_no_plots", plotLog.size(), 0);
      checkOutput("sat_ready", inReady, 1);
      clrStats = 1'b1;
      tick();
      clrStats = 1'b0;
      applyStimulus(1'b0, 0, 0, 0, 1'b0);
      checkOutput("clr_priority", dropCount, 0);
      tick();
      checkOutput("clr_hold", dropCount, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/pixel_clip_buffer.md
# pixel_clip_buffer

Downstream stage of the circle engine, in front of the VGA adapter. It accepts one pixel per handshake as signed, unclipped coordinates (octant points can fall off-screen). Each pixel is classified against the 160x120 frame and buffered in a small FIFO. Pixels are then issued to the adapter's plot interface under a grant (`out_ready`) from the plot arbiter, which shares the adapter with the fill-screen block. It also flags completion of a shape and counts clipped pixels.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `SCREEN_W`, 160: visible width; valid x is 0..SCREEN_W-1.
- `SCREEN_H`, 120: visible height; valid y is 0..SCREEN_H-1.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream pixel valid.
- `in_ready` out 1: block can accept a pixel.
- `in_x` in 10: signed two's-complement x.
- `in_y` in 10: signed two's-complement y.
- `in_colour` in 3: pixel colour.
- `in_last` in 1: marks the final pixel of a shape.
- `out_ready` in 1: arbiter grant; a pop is permitted this cycle.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out 3: registered adapter signals.
- `vga_plot` out 1: registered write strobe.
- `done` out 1: one-cycle pulse when the `in_last` entry is issued.
- `drop_count` out 16: saturating count of clipped pixels.
- `clr_stats` in 1: synchronous clear of `drop_count`.

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready = !full`, decoded from registered occupancy only. There is no combinational path from `out_ready` to `in_ready`, so a full FIFO refuses a push even while it is popping.
- Clip test on acceptance, combinational, in signed arithmetic: `vis = (in_x >= 0) && (in_x < SCREEN_W) && (in_y >= 0) && (in_y < SCREEN_H)`.
- Every accepted pixel is pushed, visible or not, as entry `{x[7:0], y[6:0], colour, vis, last}`. Clipped pixels still occupy a slot, which keeps `in_last` ordering trivial.
- Pop condition: `!empty && out_ready`.
- Cycle after a pop:
  - `vga_x`, `vga_y` and `vga_colour` take the entry's values.
  - `vga_plot = vis`.
  - `done = last`.
- Cycle with no pop: `vga_plot = 0` and `done = 0`; `vga_x`, `vga_y` and `vga_colour` hold their values.
- `drop_count` increments on every accepted pixel with `vis = 0` and saturates at 0xFFFF.
- `clr_stats` takes priority over an increment in the same cycle; the result is 0.
- Occupancy on simultaneous push and pop (possible only when not full): unchanged.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. A separate count, 0..DEPTH, distinguishes full from empty.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `vga_plot`, `done`, `vga_x`, `vga_y`, `vga_colour` = 0.
  - `drop_count` = 0.
  - FIFO empty; pointers and count = 0.
- Reset mid-stream flushes all entries with no plot and no `done`. The upstream engine is reset by the same `rst_n`.
- Latency with an empty FIFO and `out_ready` high: accept in cycle N, write at the end of N, pop in N+1, `vga_plot` high in N+2.
- Throughput is one pixel per cycle sustained when `out_ready` is held high.
- With `out_ready` low, the FIFO fills. `in_ready` drops in the cycle after the DEPTH-th accept.
- `done` is coincident with the last entry's output cycle, including when that entry is clipped (`vga_plot` = 0).
- `drop_count` updates on the clock edge ending the accept cycle.

## Structure
- Shared package `vga_pkg`:
  - `SCREEN_W`, `SCREEN_H` constants.
  - `colour_t` (logic [2:0]).
  - `pix_entry_t` packed struct `{x, y, colour, vis, last}`.
- Sub-module `sync_fifo`:
  - Parameterised by width and `DEPTH`; exposes full, empty and count.
  - Register-array storage; no vendor RAM.
- Top level holds the clip comparator, the output register and the statistics counter.

## Test plan
- Reset, then accept (10, 20, colour 3) in cycle N with `out_ready` = 1. Required: `vga_plot` = 1 only in N+2, with `vga_x` = 10, `vga_y` = 20, `vga_colour` = 3.
- Push x = -1, x = 160, y = 120 and (x = 5, y = -5). Required: four output cycles with `vga_plot` = 0 and `drop_count` = 4. Then push (159, 119). Required: plotted, and `drop_count` still 4.
- Backpressure with `out_ready` = 0: push 8 distinct pixels. Required:
  - `in_ready` = 0 after the 8th; a held 9th pixel is not accepted.
  - After raising `out_ready`, 8 consecutive plots in push order, then the 9th.
- Shape end: a 3-pixel stream whose third pixel (x = 200) carries `in_last`. Required: 2 plots, then one cycle with `done` = 1 and `vga_plot` = 0; `drop_count` +1.
- Full FIFO with `out_ready` = 1 and `in_valid` held: `in_ready` must stay 0 during the first pop cycle. Required: the accept happens the cycle after, and no entry is lost or duplicated.
- Assert `rst_n` = 0 asynchronously with 5 entries queued. Required: outputs return to zero immediately, with no plots after release. Also force `drop_count` to saturate at 0xFFFF, then pulse `clr_stats`; required: reads 0.
